mem_stream_reader: RTL and testbench

Read-side streaming front end for the accelerator's on-chip word memory (64-bit words, 32-bit word address, 1-cycle registered read, `write_en` = 0 means read). On a start command it walks a strided address sequence, drives the memory's address and write-enable ports, and captures returned words. It presents those words to the downstream compute stage as a valid/ready stream, with a small FIFO that absorbs backpressure without losing in-flight reads.

---
 rtl/mem_stream_reader.sv | 118 +++++++++++
 tb/tb_mem_stream_reader.sv | 236 +++++++++++++++++++++++
 2 files changed

// File: rtl/mem_stream_reader.sv
// Strided read-stream front end: walks base + k*stride over a 1-cycle memory and
// streams returned words through a small credit-managed FIFO.
module mem_stream_reader #(
  parameter int WIDTH      = 64,
  parameter int CNT_W      = 16,
  parameter int FIFO_DEPTH = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [31:0]      base_addr,
  input  logic [CNT_W-1:0] num_words,
  input  logic [CNT_W-1:0] stride,
  output logic             busy,
  output logic             done,
  output logic [31:0]      mem_addr,
  output logic             mem_write_en,
  input  logic [WIDTH-1:0] mem_data_out,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_data
);

  localparam int PTR_W = $clog2(FIFO_DEPTH);
  localparam logic [PTR_W+1:0] DEPTH_L = (PTR_W+2)'(FIFO_DEPTH);

  typedef enum logic [1:0] {IDLE, RUN, DRAIN} state_t;

  state_t           state;
  logic [CNT_W-1:0] remaining;
  logic [CNT_W-1:0] stride_q;
  logic             issued_v;
  logic             sampled_v;

  logic [WIDTH-1:0] fifo_mem [FIFO_DEPTH];
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic [PTR_W:0]   fifo_count;

  logic             push;
  logic             pop;
  logic [PTR_W+1:0] occupancy;
  logic             issue;
  logic             drain_done;

  // Words already buffered plus reads still in the pipe must fit in the FIFO.
  assign push       = sampled_v;
  assign pop        = out_valid && out_ready;
  assign occupancy  = (PTR_W+2)'(fifo_count) + (PTR_W+2)'(issued_v) + (PTR_W+2)'(sampled_v);
  assign issue      = (state == RUN) && (remaining != '0) && (occupancy < DEPTH_L);
  assign drain_done = (state == DRAIN) && !issued_v && !sampled_v &&
                      ((fifo_count == '0) || ((fifo_count == (PTR_W+1)'(1)) && pop));

  assign busy         = (state != IDLE);
  assign mem_write_en = 1'b0;
  assign out_valid    = (fifo_count != '0);
  assign out_data     = out_valid ? fifo_mem[rd_ptr] : '0;

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      remaining  <= '0;
      stride_q   <= '0;
      mem_addr   <= '0;
      issued_v   <= 1'b0;
      sampled_v  <= 1'b0;
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      fifo_count <= '0;
      done       <= 1'b0;
    end else begin
      done      <= 1'b0;
      sampled_v <= issued_v;
      issued_v  <= 1'b0;
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      fifo_count <= fifo_count + (PTR_W+1)'(push) - (PTR_W+1)'(pop);

      case (state)
        IDLE: begin
          if (start) begin
            stride_q <= stride;
            if (num_words == '0) begin
              remaining <= '0;
              state     <= DRAIN;
            end else begin
              mem_addr  <= base_addr;
              issued_v  <= 1'b1;
              remaining <= num_words - CNT_W'(1);
              state     <= RUN;
            end
          end
        end
        RUN: begin
          if (issue) begin
            mem_addr  <= mem_addr + 32'(stride_q);
            issued_v  <= 1'b1;
            remaining <= remaining - CNT_W'(1);
          end
          if ((remaining == '0) || (issue && (remaining == CNT_W'(1)))) state <= DRAIN;
        end
        DRAIN: begin
          // Finish on the edge that retires the last beat so done follows it directly.
          if (drain_done) begin
            state <= IDLE;
            done  <= 1'b1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (!rst && push) fifo_mem[wr_ptr] <= mem_data_out;
  end

endmodule

// File: tb/tb_mem_stream_reader.sv
// Directed bench for mem_stream_reader with a behavioural 1-cycle read memory.
module tb_mem_stream_reader;

  logic        clk = 1'b0;
  logic        rst;
  logic        start;
  logic [31:0] base_addr;
  logic [15:0] num_words;
  logic [15:0] stride;
  logic        busy;
  logic        done;
  logic [31:0] mem_addr;
  logic        mem_write_en;
  logic [63:0] mem_data_out = '0;
  logic        out_valid;
  logic        out_ready;
  logic [63:0] out_data;

  int vectors     = 0;
  int miscompares = 0;

  logic [63:0] beats[$];
  int          beat_cyc[$];
  int          done_cnt, done_cyc, busy_c0, busy_c1, busy_at_done, busy_late;
  int          wen_seen, issues_stalled, addr_changes, valid_seen, data_unstable;

  mem_stream_reader #(.WIDTH(64), .CNT_W(16), .FIFO_DEPTH(4)) dut (
    .clk(clk), .rst(rst), .start(start), .base_addr(base_addr),
    .num_words(num_words), .stride(stride), .busy(busy), .done(done),
    .mem_addr(mem_addr), .mem_write_en(mem_write_en), .mem_data_out(mem_data_out),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data)
  );

  always #5 clk = ~clk;

  // Preloaded memory contents; mem[3] mirrors mem[0].
  function automatic logic [63:0] word_at(input logic [31:0] a);
    case (a)
      32'd0:   return 64'h0104070A;
      32'd1:   return 64'h0205080B;
      32'd2:   return 64'h0306090C;
      32'd3:   return 64'h0104070A;
      default: return {a ^ 32'h5A5A0000, ~a};
    endcase
  endfunction

  always @(posedge clk) mem_data_out <= word_at(mem_addr);

  // mode 0: ready high, 1: ready low for 'stall' cycles, 2: random ready.
  task automatic do_command(input logic [31:0] b, input logic [15:0] n, input logic [15:0] s,
                            input int mode, input int stall, input int ghost);
    logic [31:0] prev_addr;
    logic [63:0] held;
    logic        held_v;
    logic        r;
    int          c;
    beats.delete();
    beat_cyc.delete();
    done_cnt = 0; done_cyc = -1; busy_at_done = -1; busy_late = -1;
    wen_seen = 0; issues_stalled = 0; addr_changes = 0; valid_seen = 0; data_unstable = 0;
    held_v = 1'b0; held = '0;
    @(negedge clk);
    prev_addr = mem_addr;
    start = 1'b1; base_addr = b; num_words = n; stride = s;
    out_ready = (mode == 0);
    c = 0;
    while (1) begin
      @(negedge clk);
      start = (c == ghost);
      if (c == 0) begin
        base_addr = 32'h0000_FFF0; num_words = 16'd9; stride = 16'd7;
      end
      case (mode)
        0:       r = 1'b1;
        1:       r = (c >= stall);
        default: r = 1'($urandom_range(0, 1));
      endcase
      out_ready = r;
      if (c == 0) busy_c0 = busy;
      if (c == 1) busy_c1 = busy;
      if (mem_write_en) wen_seen++;
      if (mem_addr != prev_addr) begin
        addr_changes++;
        if (mode == 1 && c < stall) issues_stalled++;
      end
      prev_addr = mem_addr;
      if (held_v && (!out_valid || out_data != held)) data_unstable++;
      held_v = out_valid && !r;
      held   = out_data;
      if (out_valid) valid_seen++;
      if (out_valid && r) begin
        beats.push_back(out_data);
        beat_cyc.push_back(c);
      end
      if (done) begin
        done_cnt++;
        if (done_cyc < 0) begin
          done_cyc = c;
          busy_at_done = busy;
        end
      end
      if (done_cyc >= 0 && c == done_cyc + 3) begin
        busy_late = busy;
        break;
      end
      if (c >= 400) begin
        vectors++; miscompares++;
        $display("[TB] FAIL timeout: no done within %0d cycles", c);
        break;
      end
      c++;
    end
    start = 1'b0;
    out_ready = 1'b1;
  endtask

  task automatic test_reset();
    rst = 1'b1; start = 1'b0; base_addr = '0; num_words = '0; stride = '0; out_ready = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    vectors++; if (busy !== 1'b0) begin miscompares++; $display("[TB] FAIL reset_busy: got %b want 0", busy); end
    vectors++; if (done !== 1'b0) begin miscompares++; $display("[TB] FAIL reset_done: got %b want 0", done); end
    vectors++; if (out_valid !== 1'b0) begin miscompares++; $display("[TB] FAIL reset_valid: got %b want 0", out_valid); end
    vectors++; if (out_data !== 64'h0) begin miscompares++; $display("[TB] FAIL reset_data: got %h want 0", out_data); end
    vectors++; if (mem_addr !== 32'h0) begin miscompares++; $display("[TB] FAIL reset_addr: got %h want 0", mem_addr); end
    vectors++; if (mem_write_en !== 1'b0) begin miscompares++; $display("[TB] FAIL reset_wen: got %b want 0", mem_write_en); end
    rst = 1'b0;
  endtask

  task automatic test_basic();
    logic [63:0] exp_w [3] = '{64'h0104070A, 64'h0205080B, 64'h0306090C};
    do_command(32'd0, 16'd3, 16'd1, 0, 0, -1);
    vectors++; if (beats.size() != 3) begin miscompares++; $display("[TB] FAIL basic_count: got %0d want 3", beats.size()); end
    for (int i = 0; i < 3 && i < beats.size(); i++) begin
      vectors++; if (beats[i] !== exp_w[i]) begin miscompares++; $display("[TB] FAIL basic_beat%0d: got %h want %h", i, beats[i], exp_w[i]); end
      vectors++; if (beat_cyc[i] != i + 2) begin miscompares++; $display("[TB] FAIL basic_cycle%0d: got %0d want %0d", i, beat_cyc[i], i + 2); end
    end
    vectors++; if (done_cnt != 1) begin miscompares++; $display("[TB] FAIL basic_done_count: got %0d want 1", done_cnt); end
    vectors++; if (done_cyc != 5) begin miscompares++; $display("[TB] FAIL basic_done_cycle: got %0d want 5", done_cyc); end
    vectors++; if (busy_c0 != 1) begin miscompares++; $display("[TB] FAIL basic_busy_start: got %0d want 1", busy_c0); end
    vectors++; if (busy_at_done != 0) begin miscompares++; $display("[TB] FAIL basic_busy_at_done: got %0d want 0", busy_at_done); end
    vectors++; if (wen_seen != 0) begin miscompares++; $display("[TB] FAIL basic_write_en: got %0d want 0", wen_seen); end
  endtask

  task automatic test_stride();
    do_command(32'd0, 16'd2, 16'd3, 0, 0, -1);
    vectors++; if (beats.size() != 2) begin miscompares++; $display("[TB] FAIL stride3_count: got %0d want 2", beats.size()); end
    for (int i = 0; i < beats.size(); i++) begin
      vectors++; if (beats[i] !== 64'h0104070A) begin miscompares++; $display("[TB] FAIL stride3_beat%0d: got %h want 0104070a", i, beats[i]); end
    end
    do_command(32'd2, 16'd4, 16'd0, 0, 0, -1);
    vectors++; if (beats.size() != 4) begin miscompares++; $display("[TB] FAIL stride0_count: got %0d want 4", beats.size()); end
    for (int i = 0; i < beats.size(); i++) begin
      vectors++; if (beats[i] !== 64'h0306090C) begin miscompares++; $display("[TB] FAIL stride0_beat%0d: got %h want 0306090c", i, beats[i]); end
    end
  endtask

  task automatic test_stall();
    do_command(32'd100, 16'd6, 16'd1, 1, 8, -1);
    vectors++; if (issues_stalled != 4) begin miscompares++; $display("[TB] FAIL stall_issues: got %0d want 4", issues_stalled); end
    vectors++; if (beats.size() != 6) begin miscompares++; $display("[TB] FAIL stall_count: got %0d want 6", beats.size()); end
    for (int i = 0; i < beats.size(); i++) begin
      vectors++; if (beats[i] !== word_at(32'd100 + 32'(i))) begin miscompares++; $display("[TB] FAIL stall_beat%0d: got %h want %h", i, beats[i], word_at(32'd100 + 32'(i))); end
    end
    vectors++; if (data_unstable != 0) begin miscompares++; $display("[TB] FAIL stall_hold: got %0d unstable cycles want 0", data_unstable); end
    vectors++; if (done_cnt != 1) begin miscompares++; $display("[TB] FAIL stall_done_count: got %0d want 1", done_cnt); end
  endtask

  task automatic test_random_ready();
    do_command(32'd16, 16'd32, 16'd1, 2, 0, -1);
    vectors++; if (beats.size() != 32) begin miscompares++; $display("[TB] FAIL random_count: got %0d want 32", beats.size()); end
    for (int i = 0; i < beats.size(); i++) begin
      vectors++; if (beats[i] !== word_at(32'd16 + 32'(i))) begin miscompares++; $display("[TB] FAIL random_beat%0d: got %h want %h", i, beats[i], word_at(32'd16 + 32'(i))); end
    end
    vectors++; if (data_unstable != 0) begin miscompares++; $display("[TB] FAIL random_hold: got %0d unstable cycles want 0", data_unstable); end
    vectors++; if (done_cnt != 1) begin miscompares++; $display("[TB] FAIL random_done_count: got %0d want 1", done_cnt); end
  endtask

  task automatic test_zero_count();
    do_command(32'd500, 16'd0, 16'd1, 0, 0, -1);
    vectors++; if (addr_changes != 0) begin miscompares++; $display("[TB] FAIL zero_addr: got %0d changes want 0", addr_changes); end
    vectors++; if (valid_seen != 0) begin miscompares++; $display("[TB] FAIL zero_valid: got %0d valid cycles want 0", valid_seen); end
    vectors++; if (busy_c0 != 1) begin miscompares++; $display("[TB] FAIL zero_busy0: got %0d want 1", busy_c0); end
    vectors++; if (busy_c1 != 0) begin miscompares++; $display("[TB] FAIL zero_busy1: got %0d want 0", busy_c1); end
    vectors++; if (done_cyc != 1) begin miscompares++; $display("[TB] FAIL zero_done_cycle: got %0d want 1", done_cyc); end
    vectors++; if (done_cnt != 1) begin miscompares++; $display("[TB] FAIL zero_done_count: got %0d want 1", done_cnt); end
  endtask

  task automatic test_start_ignored();
    do_command(32'd20, 16'd3, 16'd2, 0, 0, 1);
    vectors++; if (beats.size() != 3) begin miscompares++; $display("[TB] FAIL ghost_count: got %0d want 3", beats.size()); end
    for (int i = 0; i < beats.size(); i++) begin
      vectors++; if (beats[i] !== word_at(32'd20 + 32'(2 * i))) begin miscompares++; $display("[TB] FAIL ghost_beat%0d: got %h want %h", i, beats[i], word_at(32'd20 + 32'(2 * i))); end
    end
    vectors++; if (done_cnt != 1) begin miscompares++; $display("[TB] FAIL ghost_done_count: got %0d want 1", done_cnt); end
    vectors++; if (busy_late != 0) begin miscompares++; $display("[TB] FAIL ghost_busy_after: got %0d want 0", busy_late); end
  endtask

  task automatic test_reset_midcmd();
    @(negedge clk);
    start = 1'b1; base_addr = 32'd200; num_words = 16'd8; stride = 16'd1; out_ready = 1'b0;
    @(negedge clk);
    start = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    vectors++; if (busy !== 1'b0) begin miscompares++; $display("[TB] FAIL midrst_busy: got %b want 0", busy); end
    vectors++; if (done !== 1'b0) begin miscompares++; $display("[TB] FAIL midrst_done: got %b want 0", done); end
    vectors++; if (out_valid !== 1'b0) begin miscompares++; $display("[TB] FAIL midrst_valid: got %b want 0", out_valid); end
    vectors++; if (out_data !== 64'h0) begin miscompares++; $display("[TB] FAIL midrst_data: got %h want 0", out_data); end
    vectors++; if (mem_addr !== 32'h0) begin miscompares++; $display("[TB] FAIL midrst_addr: got %h want 0", mem_addr); end
    rst = 1'b0;
    out_ready = 1'b1;
    do_command(32'd40, 16'd2, 16'd2, 0, 0, -1);
    vectors++; if (beats.size() != 2) begin miscompares++; $display("[TB] FAIL fresh_count: got %0d want 2", beats.size()); end
    for (int i = 0; i < beats.size(); i++) begin
      vectors++; if (beats[i] !== word_at(32'd40 + 32'(2 * i))) begin miscompares++; $display("[TB] FAIL fresh_beat%0d: got %h want %h", i, beats[i], word_at(32'd40 + 32'(2 * i))); end
    end
    vectors++; if (done_cnt != 1) begin miscompares++; $display("[TB] FAIL fresh_done_count: got %0d want 1", done_cnt); end
  endtask

  initial begin
    $display("[TB] mem_stream_reader bench start");
    test_reset();
    test_basic();
    test_stride();
    test_stall();
    test_random_ready();
    test_zero_count();
    test_start_ignored();
    test_reset_midcmd();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
